// File: rtl/echo_delay_stage_if.sv
// Sample bus for echo_delay_stage.
//   master : upstream side, drives the sample, its strobe and the echo controls,
//            and receives the processed sample plus status.
//   slave  : echo_delay_stage side.
// Signals:
//   data_in       signed input sample, qualified by valid_in
//   valid_in      1-cycle sample strobe
//   delay_samples echo delay in samples (0 behaves as 1)
//   gain          echo gain, unsigned Q0.GAIN_W
//   feedback_en   1 = output is written back into the delay line
//   bypass        1 = data_out carries the dry sample
//   data_out      signed output sample, qualified by valid_out
//   valid_out     1-cycle output strobe
//   overrun       1-cycle pulse: a sample arrived while busy and was dropped
interface echo_delay_stage_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned GAIN_W = 8
) ();
  logic signed [WIDTH-1:0]  data_in;
  logic                     valid_in;
  logic        [ADDR_W-1:0] delay_samples;
  logic        [GAIN_W-1:0] gain;
  logic                     feedback_en;
  logic                     bypass;
  logic signed [WIDTH-1:0]  data_out;
  logic                     valid_out;
  logic                     overrun;

  modport master (
    output data_in, valid_in, delay_samples, gain, feedback_en, bypass,
    input  data_out, valid_out, overrun
  );

  modport slave (
    input  data_in, valid_in, delay_samples, gain, feedback_en, bypass,
    output data_out, valid_out, overrun
  );
endinterface

// File: rtl/echo_delay_stage.sv
// Echo delay stage for the fast audio domain.
// Accepts one signed sample per valid pulse, stores it in a circular RAM delay line and
// outputs the dry sample plus a gain-scaled, saturated copy of the sample from d samples
// earlier. With feedback enabled the output (not the dry sample) is written back, giving
// a decaying repeating echo. Each sample walks IDLE -> READ -> MAC -> WRITE, so a result
// strobe follows its input strobe by four cycles.
// Ports:
//   i_clk_fast  single clock for the block
//   i_rst       synchronous active-high reset
//   io_bus      sample/control bus (slave side), see echo_delay_stage_if
module echo_delay_stage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned GAIN_W = 8
) (
  input  logic               i_clk_fast,
  input  logic               i_rst,
  echo_delay_stage_if.slave  io_bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned ProdW = WIDTH + GAIN_W + 1;
  localparam int unsigned SumW  = ProdW + 1;

  localparam logic signed [SumW-1:0] SumMax = {{(SumW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SumW-1:0] SumMin = {{(SumW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRead, StMac, StWrite} state_e;

  state_e r_state, w_state_next;

  // Sample and controls captured at acceptance; later input changes cannot disturb them.
  logic signed [WIDTH-1:0]  r_x;
  logic        [ADDR_W-1:0] r_d;
  logic        [GAIN_W-1:0] r_gain;
  logic                     r_fb;
  logic                     r_byp;

  logic        [ADDR_W-1:0] r_wr_ptr;
  logic        [ADDR_W-1:0] r_fill;
  logic signed [WIDTH-1:0]  r_rd_data;
  logic signed [ProdW-1:0]  r_prod;
  logic signed [WIDTH-1:0]  r_data_out;
  logic                     r_valid_out;
  logic                     r_overrun;

  logic signed [WIDTH-1:0]  r_mem [Depth];

  logic                     w_accept;
  logic        [ADDR_W-1:0] w_rd_addr;
  logic signed [WIDTH-1:0]  w_dly;
  logic signed [ProdW-1:0]  w_dly_ext;
  logic signed [ProdW-1:0]  w_gain_ext;
  logic signed [ProdW-1:0]  w_scaled;
  logic signed [SumW-1:0]   w_sum;
  logic signed [WIDTH-1:0]  w_y;
  logic                     w_we;
  logic signed [WIDTH-1:0]  w_wdata;

  assign w_accept  = (r_state == StIdle) && io_bus.valid_in;
  assign w_rd_addr = r_wr_ptr - r_d;

  // Until d samples have been written the tap points at data older than the last reset,
  // so it is silenced instead of replaying stale RAM contents.
  assign w_dly      = (r_fill < r_d) ? '0 : r_rd_data;
  assign w_dly_ext  = {{(GAIN_W+1){w_dly[WIDTH-1]}}, w_dly};
  assign w_gain_ext = {{(WIDTH+1){1'b0}}, r_gain};

  // Arithmetic shift gives floor division by 2^GAIN_W (rounds toward -inf).
  assign w_scaled = r_prod >>> GAIN_W;
  assign w_sum    = {{(SumW-WIDTH){r_x[WIDTH-1]}}, r_x} + {w_scaled[ProdW-1], w_scaled};

  always_comb begin
    w_y = w_sum[WIDTH-1:0];
    if (w_sum > SumMax) begin
      w_y = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (w_sum < SumMin) begin
      w_y = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // A reset landing in WRITE discards the in-flight sample entirely.
  assign w_we    = (r_state == StWrite) && !i_rst;
  assign w_wdata = r_fb ? w_y : r_x;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.valid_in) w_state_next = StRead;
      StRead:  w_state_next = StMac;
      StMac:   w_state_next = StWrite;
      StWrite: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_fast) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_valid_out <= 1'b0;
      r_overrun   <= io_bus.valid_in && (r_state != StIdle);
      if (r_state == StWrite) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        if (r_fill != '1) r_fill <= r_fill + ADDR_W'(1);
        r_data_out  <= r_byp ? r_x : w_y;
        r_valid_out <= 1'b1;
      end
    end
  end

  // Datapath holding registers need no reset: they are only consumed after a capture.
  always_ff @(posedge i_clk_fast) begin
    if (w_accept) begin
      r_x    <= io_bus.data_in;
      r_d    <= (io_bus.delay_samples == '0) ? ADDR_W'(1) : io_bus.delay_samples;
      r_gain <= io_bus.gain;
      r_fb   <= io_bus.feedback_en;
      r_byp  <= io_bus.bypass;
    end
    if (r_state == StMac) begin
      r_prod <= w_dly_ext * w_gain_ext;
    end
  end

  // Delay line: single write port, registered read. The address presented in READ is
  // available as r_rd_data during MAC.
  always_ff @(posedge i_clk_fast) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign io_bus.data_out  = r_data_out;
  assign io_bus.valid_out = r_valid_out;
  assign io_bus.overrun   = r_overrun;
endmodule

// File: tb/tb_echo_delay_stage.sv
// Self-checking bench for echo_delay_stage: directed and $urandom stimulus compared with
// a sample-level reference model of the echo line.
module tb_echo_delay_stage;
  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  echo_delay_stage_if bus ();

  echo_delay_stage dut (
    .i_clk_fast (clk),
    .i_rst      (rst),
    .io_bus     (bus)
  );

  // Reference model: whole-sample view of the delay line.
  int m_line [4096];
  int m_wp;
  int m_fill;

  task automatic model_reset();
    m_wp   = 0;
    m_fill = 0;
  endtask

  task automatic model_step(input int x, input int dsamp, input int g, input bit fb,
                            input bit byp, output int exp_y);
    int d, dly, p, sc, s;
    d   = (dsamp == 0) ? 1 : dsamp;
    dly = (m_fill < d) ? 0 : m_line[(m_wp - d + 4096) % 4096];
    p   = dly * g;
    sc  = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    s   = x + sc;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    m_line[m_wp] = fb ? s : x;
    m_wp = (m_wp + 1) % 4096;
    if (m_fill < 4095) m_fill++;
    exp_y = byp ? x : s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Entered at a negedge in cycle N; returns at the negedge of cycle N+4.
  // Bit k of the sequences holds the output seen in cycle N+1+k.
  task automatic drive_sample(input int x, input int dsamp, input int g, input bit fb,
                              input bit byp, input bit scramble,
                              output logic signed [15:0] y, output logic [3:0] vo_seq,
                              output logic [3:0] ov_seq);
    bus.data_in       = 16'(x);
    bus.delay_samples = 12'(dsamp);
    bus.gain          = 8'(g);
    bus.feedback_en   = fb;
    bus.bypass        = byp;
    bus.valid_in      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (scramble) begin
        bus.data_in       = 16'($urandom);
        bus.delay_samples = 12'($urandom);
        bus.gain          = 8'($urandom);
        bus.feedback_en   = 1'($urandom);
        bus.bypass        = 1'($urandom);
      end
      vo_seq[k] = bus.valid_out;
      ov_seq[k] = bus.overrun;
    end
    y = bus.data_out;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.data_out !== 16'sd0) begin
      errors++; $display("FAIL reset_data_out: got %0d want 0", bus.data_out);
    end
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    end
  endtask

  task automatic test_impulse();
    int tbl [12] = '{1000, 0, 0, 0, 500, 0, 0, 0, 0, 0, 0, 0};
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_sample((i == 0) ? 1000 : 0, 4, 128, 1'b0, 1'b0, 1'b0, y, vo, ov);
      model_step((i == 0) ? 1000 : 0, 4, 128, 1'b0, 1'b0, e);
      checks++;
      if (vo !== 4'b1000) begin
        errors++; $display("FAIL impulse_latency[%0d]: got %b want 1000", i, vo);
      end
      checks++;
      if (y !== 16'(tbl[i])) begin
        errors++; $display("FAIL impulse_data[%0d]: got %0d want %0d", i, y, tbl[i]);
      end
    end
  endtask

  task automatic test_feedback();
    int pos [5] = '{1000, 500, 250, 125, 62};
    int neg [5] = '{-1000, -500, -250, -125, -63};
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int x, want, e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 20; i++) begin
        x = (i == 0) ? ((pass == 0) ? 1000 : -1000) : 0;
        want = ((i % 4) == 0) ? ((pass == 0) ? pos[i/4] : neg[i/4]) : 0;
        drive_sample(x, 4, 128, 1'b1, 1'b0, 1'b0, y, vo, ov);
        model_step(x, 4, 128, 1'b1, 1'b0, e);
        checks++;
        if (vo !== 4'b1000 || y !== 16'(want)) begin
          errors++;
          $display("FAIL feedback[p%0d,%0d]: got %0d vo=%b want %0d vo=1000", pass, i, y, vo,
                   want);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int x, want, e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      x = (pass == 0) ? 30000 : -30000;
      for (int i = 0; i < 6; i++) begin
        want = (i == 0) ? x : ((pass == 0) ? 32767 : -32768);
        drive_sample(x, 1, 255, 1'b0, 1'b0, 1'b0, y, vo, ov);
        model_step(x, 1, 255, 1'b0, 1'b0, e);
        checks++;
        if (y !== 16'(want)) begin
          errors++; $display("FAIL saturation[p%0d,%0d]: got %0d want %0d", pass, i, y, want);
        end
      end
    end
  endtask

  task automatic test_fill_mask();
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    logic [5:0] vo_r;
    int x, d, g, e;
    bit fb, byp;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      x = int'($urandom_range(65535)) - 32768;
      d = int'($urandom_range(300));
      g = int'($urandom_range(255));
      fb = 1'($urandom); byp = 1'($urandom);
      drive_sample(x, d, g, fb, byp, 1'b0, y, vo, ov);
      model_step(x, d, g, fb, byp, e);
      checks++;
      if (vo !== 4'b1000 || y !== 16'(e)) begin
        errors++; $display("FAIL random_run[%0d]: got %0d vo=%b want %0d", i, y, vo, e);
      end
    end
    // Reset while the next sample is in MAC: it must never emerge.
    bus.data_in = 16'sd4321; bus.valid_in = 1'b1;
    @(negedge clk); bus.valid_in = 1'b0; vo_r[0] = bus.valid_out;
    @(negedge clk); rst = 1'b1;          vo_r[1] = bus.valid_out;
    @(negedge clk); rst = 1'b0;          vo_r[2] = bus.valid_out;
    for (int k = 3; k < 6; k++) begin
      @(negedge clk); vo_r[k] = bus.valid_out;
    end
    model_reset();
    checks++;
    if (vo_r !== 6'b000000) begin
      errors++; $display("FAIL midop_reset_valid: got %b want 000000", vo_r);
    end
    checks++;
    if (bus.data_out !== 16'sd0) begin
      errors++; $display("FAIL midop_reset_data: got %0d want 0", bus.data_out);
    end
    for (int i = 0; i < 110; i++) begin
      x = int'($urandom_range(65535)) - 32768;
      if (i == 0) x = 20000;
      drive_sample(x, 100, 255, 1'b0, 1'b0, 1'b0, y, vo, ov);
      model_step(x, 100, 255, 1'b0, 1'b0, e);
      if (i < 100) begin
        checks++;
        if (y !== 16'(x)) begin
          errors++; $display("FAIL fill_mask_dry[%0d]: got %0d want %0d", i, y, x);
        end
      end
      checks++;
      if (y !== 16'(e)) begin
        errors++; $display("FAIL fill_mask_echo[%0d]: got %0d want %0d", i, y, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int x, e;
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      x = (((i * 13) % 4000) - 2000) * 8;
      drive_sample(x, 4095, 64, 1'b0, 1'b0, 1'b0, y, vo, ov);
      model_step(x, 4095, 64, 1'b0, 1'b0, e);
      checks++;
      if (vo !== 4'b1000 || y !== 16'(e)) begin
        errors++; $display("FAIL wrap[%0d]: got %0d vo=%b want %0d", i, y, vo, e);
      end
    end
  endtask

  task automatic test_delay0();
    int xs [60];
    logic signed [15:0] y0 [60];
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int e;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      xs[i] = int'($urandom_range(40000)) - 20000;
      drive_sample(xs[i], 0, 200, 1'b1, 1'b0, 1'b0, y0[i], vo, ov);
      model_step(xs[i], 0, 200, 1'b1, 1'b0, e);
      checks++;
      if (y0[i] !== 16'(e)) begin
        errors++; $display("FAIL delay0[%0d]: got %0d want %0d", i, y0[i], e);
      end
    end
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drive_sample(xs[i], 1, 200, 1'b1, 1'b0, 1'b0, y, vo, ov);
      model_step(xs[i], 1, 200, 1'b1, 1'b0, e);
      checks++;
      if (y !== y0[i] || y !== 16'(e)) begin
        errors++;
        $display("FAIL delay1_vs_0[%0d]: got %0d want %0d (delay0 gave %0d)", i, y, e, y0[i]);
      end
    end
  endtask

  task automatic test_bypass();
    int xs   [6] = '{1000, 0, 0, 0, 0, 0};
    bit byps [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int tbl  [6] = '{1000, 0, 0, 500, 0, 0};
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_sample(xs[i], 3, 128, 1'b0, byps[i], 1'b0, y, vo, ov);
      model_step(xs[i], 3, 128, 1'b0, byps[i], e);
      checks++;
      if (y !== 16'(tbl[i])) begin
        errors++; $display("FAIL bypass[%0d]: got %0d want %0d", i, y, tbl[i]);
      end
    end
  endtask

  task automatic test_random_ctrl();
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    int x, d, g, e;
    bit fb, byp;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(65535)) - 32768;
      d = int'($urandom_range(15));
      g = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(255));
      fb = 1'($urandom); byp = 1'($urandom);
      drive_sample(x, d, g, fb, byp, 1'b1, y, vo, ov);
      model_step(x, d, g, fb, byp, e);
      checks++;
      if (vo !== 4'b1000 || ov !== 4'b0000 || y !== 16'(e)) begin
        errors++;
        $display("FAIL random_ctrl[%0d]: got %0d vo=%b ov=%b want %0d", i, y, vo, ov, e);
      end
      if (g == 0) begin
        checks++;
        if (y !== 16'(x)) begin
          errors++; $display("FAIL gain0[%0d]: got %0d want %0d", i, y, x);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] y;
    logic [3:0] vo, ov;
    logic [5:0] vo_s, ov_s;
    logic signed [15:0] y_first;
    int x, e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(20000)) - 10000;
      drive_sample(x, 2, 128, 1'b0, 1'b0, 1'b0, y, vo, ov);
      model_step(x, 2, 128, 1'b0, 1'b0, e);
    end
    bus.data_in = 16'sd1234; bus.delay_samples = 12'd2; bus.gain = 8'd128;
    bus.feedback_en = 1'b0; bus.bypass = 1'b0; bus.valid_in = 1'b1;
    y_first = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.valid_in = (k == 1);
      if (k == 1) bus.data_in = -16'sd777;
      vo_s[k] = bus.valid_out;
      ov_s[k] = bus.overrun;
      if (k == 3) y_first = bus.data_out;
    end
    bus.valid_in = 1'b0;
    model_step(1234, 2, 128, 1'b0, 1'b0, e);
    checks++;
    if (ov_s !== 6'b000100) begin
      errors++; $display("FAIL overrun_pulse: got %b want 000100", ov_s);
    end
    checks++;
    if (vo_s !== 6'b001000) begin
      errors++; $display("FAIL overrun_valid_out: got %b want 001000", vo_s);
    end
    checks++;
    if (y_first !== 16'(e)) begin
      errors++; $display("FAIL overrun_data: got %0d want %0d", y_first, e);
    end
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(20000)) - 10000;
      drive_sample(x, 2, 128, 1'b0, 1'b0, 1'b0, y, vo, ov);
      model_step(x, 2, 128, 1'b0, 1'b0, e);
      checks++;
      if (y !== 16'(e)) begin
        errors++; $display("FAIL overrun_after[%0d]: got %0d want %0d", i, y, e);
      end
    end
  endtask

  initial begin
    bus.data_in       = '0;
    bus.valid_in      = 1'b0;
    bus.delay_samples = '0;
    bus.gain          = '0;
    bus.feedback_en   = 1'b0;
    bus.bypass        = 1'b0;
    test_reset();
    test_impulse();
    test_feedback();
    test_saturation();
    test_bypass();
    test_delay0();
    test_overrun();
    test_random_ctrl();
    test_fill_mask();
    test_wrap();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
